// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the control state enum and the counter
// width helper used to size the iteration counter.
package muldiv_pkg;

  localparam logic [1:0] MD_DIVU  = 2'b00;
  localparam logic [1:0] MD_DIV   = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_MULT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIXUP,
    DONE
  } state_t;

  // Bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared shift datapath.
// mode=0: restoring-divide step. The partial remainder is shifted left with
//         shift_in (next dividend bit); the divisor is subtracted if it fits.
//         q_bit is the resulting quotient bit.
// mode=1: shift-add multiply step. shift_in is the current multiplier bit;
//         the multiplicand is added when it is set and the sum is shifted
//         right. q_bit is the bit shifted out of the sum into the low half.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] part,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] opd,
  input  logic             mode,
  output logic [WIDTH-1:0] part_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  // Single divide or multiply iteration.
  always_comb begin
    trial     = {part, shift_in};
    diff      = trial - {1'b0, opd};
    sum       = {1'b0, part} + ({(WIDTH+1){shift_in}} & {1'b0, opd});
    part_next = trial[WIDTH-1:0];
    q_bit     = 1'b0;
    if (mode) begin
      part_next = sum[WIDTH:1];
      q_bit     = sum[0];
    end else if (!diff[WIDTH]) begin
      part_next = diff[WIDTH-1:0];
      q_bit     = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned divide (and optional multiply).
// One operation per opn handshake, WIDTH iterations on a shared shift
// datapath, result held until the res handshake. Divide by zero returns
// quotient all-ones, remainder = a, and raises div_by_zero.
// Build option: define MULDIV_MUL_EN to enable iterative multiply; without
// it, multiply ops complete immediately with a zero result.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               opn_valid,
  output logic               opn_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               busy
);

  localparam int CW = clog2(WIDTH);

`ifdef MULDIV_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               sgn_q;
  logic               mul_q;
  logic               neg_q;
  logic               rneg_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   part_next;
  logic [WIDTH-1:0]   lo_next;
  logic               q_bit;
  logic               shift_in;
  logic               accept;
  logic               op_is_mul;
  logic               op_is_sgn;
  logic               skip_mul;
  logic               prep_dbz;
  logic [2*WIDTH-1:0] fix_val;

  // Two's-complement negate when en is set (magnitude / sign restore).
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  assign op_is_mul = (op == MD_MULTU) || (op == MD_MULT);
  assign op_is_sgn = (op == MD_DIV) || (op == MD_MULT);
  assign skip_mul  = op_is_mul && !MUL_ON;
  assign opn_ready = (state == IDLE) && !flush;
  assign accept    = opn_valid && opn_ready;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Low half holds the dividend / multiplier, high half the partial value.
  assign hi       = acc[2*WIDTH-1:WIDTH];
  assign lo       = acc[WIDTH-1:0];
  assign prep_dbz = !mul_q && (opd == '0);
  assign shift_in = mul_q ? lo[0] : lo[WIDTH-1];
  assign lo_next  = mul_q ? {q_bit, lo[WIDTH-1:1]} : {lo[WIDTH-2:0], q_bit};
  assign fix_val  = mul_q ? neg2_if(acc, neg_q) : {neg_if(hi, rneg_q), neg_if(lo, neg_q)};

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part      (hi),
    .shift_in  (shift_in),
    .opd       (opd),
    .mode      (mul_q),
    .part_next (part_next),
    .q_bit     (q_bit)
  );

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = skip_mul ? DONE : PREP;
      PREP:    state_next = prep_dbz ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: operand latch, magnitude prep and the iteration loop.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          sgn_q <= op_is_sgn;
          mul_q <= op_is_mul && MUL_ON;
          if (op_is_mul) begin
            acc[WIDTH-1:0] <= b;
            opd            <= a;
          end else begin
            acc[WIDTH-1:0] <= a;
            opd            <= b;
          end
        end
      end
      PREP: begin
        acc    <= {{WIDTH{1'b0}}, neg_if(lo, sgn_q && lo[WIDTH-1])};
        opd    <= neg_if(opd, sgn_q && opd[WIDTH-1]);
        neg_q  <= sgn_q && (lo[WIDTH-1] ^ opd[WIDTH-1]);
        rneg_q <= sgn_q && lo[WIDTH-1];
        cnt    <= CW'(WIDTH - 1);
      end
      CALC: begin
        acc <= {part_next, lo_next};
        cnt <= cnt - CW'(1);
      end
      default: ;
    endcase
  end

  // Result register: written only on entry to DONE, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      if ((state == IDLE) && accept && skip_mul) begin
        result      <= '0;
        div_by_zero <= 1'b0;
      end else if ((state == PREP) && prep_dbz) begin
        result      <= {lo, {WIDTH{1'b1}}};
        div_by_zero <= 1'b1;
      end else if (state == FIXUP) begin
        result      <= fix_val;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter (WIDTH=32).
// The driver pushes expected results as it issues operations; a monitor
// pops and compares whenever the unit presents a result.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           opn_valid;
  logic           opn_ready;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           flush;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] result;
  logic           div_by_zero;
  logic           busy;

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .opn_valid   (opn_valid),
    .opn_ready   (opn_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one operation; when track is set, queue its expected response.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit track, input logic [63:0] r, input logic d,
                       input int lat, input string nm);
    exp_t e;
    int   t;
    @(negedge clk);
    op = o; a = x; b = y; opn_valid = 1'b1;
    #1;
    t = 0;
    while (!opn_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (!opn_ready) begin
      n_chk++; n_fail++;
      $display("FAIL %s_accept: opn_ready stuck low", nm);
    end
    if (track) begin
      e.res = r; e.dbz = d; e.lat = lat; e.acc = cyc + 1;
      q.push_back(e);
      qn.push_back(nm);
    end
    @(posedge clk); #1;
    opn_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((busy || q.size() != 0) && t < 200) begin
      @(negedge clk); t++;
    end
    n_chk++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL %s_idle: timeout busy=%0b pending=%0d", nm, busy, q.size());
    end
  endtask

  // Monitor: compare each presented result against the scoreboard.
  initial begin : monitor
    exp_t  e;
    string nm;
    bit    have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        have = 1'b0;
      end else if (res_valid === 1'b1) begin
        if (!have) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_result: got %h with nothing pending", result);
          end else begin
            e = q.pop_front();
            nm = qn.pop_front();
            have = 1'b1;
            check({nm, "_result"}, result, e.res);
            check({nm, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
            if (e.lat > 0) check({nm, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
          end
        end else begin
          check({nm, "_hold_result"}, result, e.res);
          check({nm, "_hold_opn_ready"}, 64'(opn_ready), 64'(0));
        end
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    rst = 1'b1; opn_valid = 1'b0; op = MD_DIVU; a = '0; b = '0;
    flush = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_res_valid", 64'(res_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_result", result, 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;
    #1 check("reset_opn_ready", 64'(opn_ready), 64'(1));

    // Unsigned and signed divides.
    issue(MD_DIVU, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 1'b0, 35, "divu_100_7");
    wait_idle("divu_100_7");
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 35, "div_m7_2");
    wait_idle("div_m7_2");
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1, {32'h0, 32'h80000000}, 1'b0, 35, "div_min_m1");
    wait_idle("div_min_m1");
    issue(MD_DIV, 32'd7, 32'hFFFFFFFE, 1, {32'd1, 32'hFFFFFFFD}, 1'b0, 35, "div_7_m2");
    wait_idle("div_7_m2");
    issue(MD_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 1, {32'hFFFFFFFE, 32'd2}, 1'b0, 35, "div_m8_m3");
    wait_idle("div_m8_m3");
    issue(MD_DIVU, 32'hFFFFFFFF, 32'd1, 1, {32'd0, 32'hFFFFFFFF}, 1'b0, 35, "divu_max_1");
    wait_idle("divu_max_1");

    // Divide by zero.
    issue(MD_DIVU, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1'b1, 2, "divu_5_0");
    wait_idle("divu_5_0");
    issue(MD_DIV, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1'b1, 2, "div_5_0");
    wait_idle("div_5_0");
    issue(MD_DIV, 32'hFFFFFFFB, 32'd0, 1, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 2, "div_m5_0");
    wait_idle("div_m5_0");

    // Multiply.
`ifdef MULDIV_MUL_EN
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 1, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 35, "mult_m3_5");
    wait_idle("mult_m3_5");
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001, 1'b0, 35, "multu_max");
    wait_idle("multu_max");
    issue(MD_MULT, 32'h80000000, 32'hFFFFFFFF, 1, 64'h00000000_80000000, 1'b0, 35, "mult_min_m1");
    wait_idle("mult_min_m1");
`else
    issue(MD_MULT, 32'hFFFFFFFD, 32'd5, 1, 64'h0, 1'b0, 1, "mult_off");
    wait_idle("mult_off");
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'h0, 1'b0, 1, "multu_off");
    wait_idle("multu_off");
`endif

    // Result hold with res_ready low for 10 cycles.
    res_ready = 1'b0;
    issue(MD_DIVU, 32'd20, 32'd6, 1, {32'd2, 32'd3}, 1'b0, 35, "hold_20_6");
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge clk); t++;
    end
    check("hold_valid_seen", 64'(res_valid), 64'(1));
    repeat (10) @(negedge clk);
    check("hold_still_valid", 64'(res_valid), 64'(1));
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_idle", 64'(busy), 64'(0));
    check("hold_release_ready", 64'(opn_ready), 64'(1));
    wait_idle("hold_20_6");

    // Flush in CALC cycle 10 with a competing request held high.
    issue(MD_DIVU, 32'd1000, 32'd3, 0, 64'h0, 1'b0, 0, "flushed");
    repeat (11) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'(1));
    flush = 1'b1; opn_valid = 1'b1; op = MD_DIVU; a = 32'd50; b = 32'd5;
    #1 check("flush_opn_ready", 64'(opn_ready), 64'(0));
    @(posedge clk); #1;
    check("flush_idle", 64'(busy), 64'(0));
    check("flush_no_valid", 64'(res_valid), 64'(0));
    flush = 1'b0; opn_valid = 1'b0;
    @(negedge clk);
    check("flush_not_accepted", 64'(busy), 64'(0));
    issue(MD_DIVU, 32'd9, 32'd3, 1, {32'd0, 32'd3}, 1'b0, 35, "divu_9_3");
    wait_idle("divu_9_3");

    // Reset mid-CALC after a flagged result, so every output has to clear.
    issue(MD_DIVU, 32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1'b1, 2, "pre_rst_dbz");
    wait_idle("pre_rst_dbz");
    issue(MD_DIVU, 32'd1000, 32'd7, 0, 64'h0, 1'b0, 0, "reset_victim");
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_res_valid", 64'(res_valid), 64'(0));
    check("rst_mid_result", result, 64'(0));
    check("rst_mid_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_ready", 64'(opn_ready), 64'(1));
    issue(MD_DIVU, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 1'b0, 35, "post_rst_divu");
    wait_idle("post_rst_divu");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
